// File: rtl/arb_egress_buffer.sv
// Egress buffer behind the arbiter: tags granted words with their source, queues them, drains over valid/ready.
// Optional per-source accepted-word statistics are enabled with `define OUT_STATS_EN.
module arb_egress_buffer #(
   parameter int unsigned NUM_REQS    = 4,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HOLD_MARGIN = 1,
   parameter int unsigned CNTW        = 8,
   localparam int unsigned SRCW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQS-1:0] in_gnt,
   input  logic [WIDTH-1:0]    in_data,
   output logic                hold,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [SRCW-1:0]     out_src,
   output logic [CW-1:0]       count,
   output logic                overflow,
   output logic                gnt_err
`ifdef OUT_STATS_EN
   ,
   input  logic [SRCW-1:0]     stat_sel,
   output logic [CNTW-1:0]     stat_cnt
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic [SRCW-1:0]  mem_src  [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   logic             push;
   logic             pop;
   logic             full;
   logic             wr_en;
   logic             drop;
   logic             multi_gnt;
   logic [SRCW-1:0]  src_enc;
   logic [CW-1:0]    count_next;
   logic             hold_next;

   // Lowest set grant bit wins when the grant is not one-hot
   always_comb begin
      src_enc = '0;
      for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
         if (in_gnt[i]) src_enc = SRCW'(i);
      end
   end

   assign multi_gnt = (in_gnt & (in_gnt - NUM_REQS'(1))) != '0;
   assign push      = |in_gnt;
   assign pop       = out_valid & out_ready;
   assign full      = count == CW'(DEPTH);
   assign wr_en     = push & (~full | pop);
   assign drop      = push & full & ~pop;

   always_comb begin
      count_next = count;
      case ({wr_en, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Hold looks at post-edge occupancy so the arbiter sees it one cycle ahead of the next grant
   assign hold_next = (CW'(DEPTH) - count_next) <= CW'(HOLD_MARGIN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         hold      <= 1'b0;
         overflow  <= 1'b0;
         gnt_err   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         count     <= count_next;
         out_valid <= count_next != '0;
         hold      <= hold_next;
         if (drop)      overflow <= 1'b1;
         if (multi_gnt) gnt_err  <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only observed behind out_valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr] <= in_data;
         mem_src[wr_ptr]  <= src_enc;
      end
   end

   assign out_data = out_valid ? mem_data[rd_ptr] : '0;
   assign out_src  = out_valid ? mem_src[rd_ptr]  : '0;

`ifdef OUT_STATS_EN
   logic [CNTW-1:0] stat_q [NUM_REQS];

   // Saturating count of stored words per source; dropped words are not counted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NUM_REQS); i++) stat_q[i] <= '0;
      end else if (wr_en && stat_q[src_enc] != '1) begin
         stat_q[src_enc] <= stat_q[src_enc] + CNTW'(1);
      end
   end

   assign stat_cnt = stat_q[stat_sel];
`endif

endmodule
